// File: rtl/uop_decode_queue.sv
// Decode stage: cracks one ARM instruction per cycle into 1-2 micro-ops and queues them for issue.
// Define UOP_DECODE_STATS_EN to add the stat_instr_o / stat_uop_o / stat_stall_o counters.
module uop_decode_queue #(
    parameter int UOP_WIDTH = 64,
    parameter int DEPTH     = 4,
    parameter int REG_IDX_W = 5,
    parameter int TMP_REG   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  logic [31:0]            instr_i,
    output logic                   uop_valid_o,
    input  logic                   uop_ready_i,
    output logic [UOP_WIDTH-1:0]   uop_o,
    output logic [$clog2(DEPTH):0] count_o
`ifdef UOP_DECODE_STATS_EN
    ,
    output logic [31:0]            stat_instr_o,
    output logic [31:0]            stat_uop_o,
    output logic [31:0]            stat_stall_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Micro-op field layout, low to high: imm12, src0, src1, src2, dst0, dst valid, type, class; cond and valid at the top.
    localparam int UOP_I_IMM_12_LO = 0;
    localparam int UOP_I_SRC_0_LO  = 12;
    localparam int UOP_I_SRC_1_LO  = UOP_I_SRC_0_LO + REG_IDX_W;
    localparam int UOP_I_SRC_2_LO  = UOP_I_SRC_1_LO + REG_IDX_W;
    localparam int UOP_I_DST_0_LO  = UOP_I_SRC_2_LO + REG_IDX_W;
    localparam int UOP_I_DST_0_V   = UOP_I_DST_0_LO + REG_IDX_W;
    localparam int UOP_I_TYPE_LO   = UOP_I_DST_0_V + 1;
    localparam int UOP_CLASS_LO    = UOP_I_TYPE_LO + 4;
    localparam int UOP_COND_LO     = UOP_WIDTH - 5;
    localparam int UOP_VALID_B     = UOP_WIDTH - 1;

    localparam logic [2:0] UOP_CLASS_INTEGER   = 3'd1;
    localparam logic [2:0] UOP_CLASS_INTEGER_M = 3'd2;
    localparam logic [2:0] UOP_CLASS_LOAD      = 3'd3;
    localparam logic [2:0] UOP_CLASS_STORE     = 3'd4;
    localparam logic [3:0] UOP_I_TYPE_REG       = 4'd0;
    localparam logic [3:0] UOP_I_TYPE_IMM       = 4'd1;
    localparam logic [3:0] UOP_I_TYPE_SHIFT_LSL = 4'd4;
    localparam logic [3:0] COND_AL              = 4'hE;

    typedef logic [REG_IDX_W-1:0] ridx_t;
    typedef logic [UOP_WIDTH-1:0] uop_t;

    function automatic uop_t mk_uop(input logic [3:0] cond, input logic [2:0] cls,
                                    input logic [3:0] typ, input logic [11:0] imm,
                                    input ridx_t s0, input ridx_t s1, input ridx_t s2,
                                    input ridx_t d, input logic dv);
        uop_t u;
        u = '0;
        u[UOP_VALID_B]                      = 1'b1;
        u[UOP_COND_LO +: 4]                 = cond;
        u[UOP_CLASS_LO +: 3]                = cls;
        u[UOP_I_TYPE_LO +: 4]               = typ;
        u[UOP_I_IMM_12_LO +: 12]            = imm;
        u[UOP_I_SRC_0_LO +: REG_IDX_W]      = s0;
        u[UOP_I_SRC_1_LO +: REG_IDX_W]      = s1;
        u[UOP_I_SRC_2_LO +: REG_IDX_W]      = s2;
        u[UOP_I_DST_0_LO +: REG_IDX_W]      = dv ? d : '0;
        u[UOP_I_DST_0_V]                    = dv;
        return u;
    endfunction

    logic [3:0] cond;
    ridx_t      rn, rd, rm, rs, tmp;
    logic       dp_misc, dp_dv;
    logic [3:0] shift_typ;
    uop_t       uop_a, uop_b;
    logic [1:0] n_uops;

    assign cond      = instr_i[31:28];
    assign rn        = ridx_t'(instr_i[19:16]);
    assign rd        = ridx_t'(instr_i[15:12]);
    assign rs        = ridx_t'(instr_i[11:8]);
    assign rm        = ridx_t'(instr_i[3:0]);
    assign tmp       = ridx_t'(TMP_REG);
    // Test opcodes with S=0 live in the MSR/hint/misc space rather than data processing.
    assign dp_misc   = (instr_i[24:23] == 2'b10) && !instr_i[20];
    assign dp_dv     = (instr_i[24:23] != 2'b10);
    assign shift_typ = UOP_I_TYPE_SHIFT_LSL + {2'b00, instr_i[6:5]};

    always_comb begin
        uop_a  = '0;
        uop_b  = '0;
        n_uops = 2'd0;
        if (cond != 4'hF) begin
            if (instr_i[27:25] == 3'b001 && !dp_misc) begin
                uop_a  = mk_uop(cond, UOP_CLASS_INTEGER, UOP_I_TYPE_IMM, instr_i[11:0],
                                rn, '0, '0, rd, dp_dv);
                n_uops = 2'd1;
            end else if (instr_i[27:22] == 6'b000000 && instr_i[7:4] == 4'b1001) begin
                // Multiply encodings swap the roles of [19:16] and [15:12].
                uop_a  = mk_uop(cond, UOP_CLASS_INTEGER_M, UOP_I_TYPE_REG, 12'h000,
                                rm, rs, rd, rn, 1'b1);
                n_uops = 2'd1;
            end else if (instr_i[27:25] == 3'b000 && !dp_misc && !(instr_i[7] && instr_i[4])) begin
                if (instr_i[11:4] == 8'h00) begin
                    uop_a  = mk_uop(cond, UOP_CLASS_INTEGER, UOP_I_TYPE_REG, 12'h000,
                                    rn, rm, '0, rd, dp_dv);
                    n_uops = 2'd1;
                end else begin
                    // Shift runs unconditionally into the temp; the ALU op carries the condition.
                    uop_a  = mk_uop(COND_AL, UOP_CLASS_INTEGER, shift_typ, instr_i[11:0],
                                    '0, rm, instr_i[4] ? rs : '0, tmp, 1'b1);
                    uop_b  = mk_uop(cond, UOP_CLASS_INTEGER, UOP_I_TYPE_REG, 12'h000,
                                    rn, tmp, '0, rd, dp_dv);
                    n_uops = 2'd2;
                end
            end else if (instr_i[27:26] == 2'b01 && !(instr_i[25] && instr_i[4])) begin
                if (instr_i[20])
                    uop_a = mk_uop(cond, UOP_CLASS_LOAD, UOP_I_TYPE_IMM, instr_i[11:0],
                                   rn, '0, '0, rd, 1'b1);
                else
                    uop_a = mk_uop(cond, UOP_CLASS_STORE, UOP_I_TYPE_IMM, instr_i[11:0],
                                   rn, rd, '0, '0, 1'b0);
                n_uops = 2'd1;
            end
        end
    end

    logic [DEPTH-1:0][UOP_WIDTH-1:0] mem;
    logic [PW-1:0] wptr, rptr, wptr1, rptr_n;
    logic [CW-1:0] count, count_n, left;
    logic          accept, deq;
    logic [1:0]    n_enq;

    // Two free slots are always required so a cracked pair never has to be split.
    assign instr_ready_o = rst && !flush_i && ((CW'(DEPTH) - count) >= CW'(2));
    assign uop_valid_o   = (count != '0);
    assign count_o       = count;

    assign accept  = instr_valid_i && instr_ready_o;
    assign n_enq   = accept ? n_uops : 2'd0;
    assign deq     = uop_valid_o && uop_ready_i && !flush_i;
    assign wptr1   = wptr + PW'(1);
    assign rptr_n  = rptr + PW'(deq);
    assign left    = count - CW'(deq);
    assign count_n = left + CW'(n_enq);

    always_ff @(posedge clk) begin
        if (n_enq != 2'd0) mem[wptr] <= uop_a;
        if (n_enq == 2'd2) mem[wptr1] <= uop_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            uop_o <= '0;
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(n_enq);
            rptr  <= rptr_n;
            count <= count_n;
            // When the queue drains this cycle the new head is the uop being written now.
            if (count_n != '0) uop_o <= (left != '0) ? mem[rptr_n] : uop_a;
        end
    end

`ifdef UOP_DECODE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_instr_o <= '0;
            stat_uop_o   <= '0;
            stat_stall_o <= '0;
        end else begin
            stat_instr_o <= stat_instr_o + 32'(accept);
            stat_uop_o   <= stat_uop_o + 32'(deq);
            stat_stall_o <= stat_stall_o + 32'(instr_valid_i && !instr_ready_o);
        end
    end
`endif

endmodule

// File: tb/tb_uop_decode_queue.sv
// Bench for uop_decode_queue: decode vector table, directed reset/stall/flush sequences,
// and a randomized run against a queue-based reference model.
module tb_uop_decode_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic        uop_ready_i = 1'b0;
    logic [31:0] instr_i = 32'h0;
    logic        instr_ready_o, uop_valid_o;
    logic [63:0] uop_o;
    logic [2:0]  count_o;
`ifdef UOP_DECODE_STATS_EN
    logic [31:0] stat_instr_o, stat_uop_o, stat_stall_o;
`endif

    uop_decode_queue #(.UOP_WIDTH(64), .DEPTH(DEPTH), .REG_IDX_W(5), .TMP_REG(16)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
        .uop_valid_o(uop_valid_o), .uop_ready_i(uop_ready_i), .uop_o(uop_o), .count_o(count_o)
`ifdef UOP_DECODE_STATS_EN
        , .stat_instr_o(stat_instr_o), .stat_uop_o(stat_uop_o), .stat_stall_o(stat_stall_o)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected micro-op built from named fields; bit positions written out explicitly.
    function automatic logic [63:0] mk(input logic [3:0] cond, input logic [2:0] cls,
                                       input logic [3:0] typ, input logic [11:0] imm,
                                       input logic [4:0] s0, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [4:0] d,
                                       input logic dv);
        logic [63:0] u;
        u        = 64'd0;
        u[63]    = 1'b1;
        u[62:59] = cond;
        u[39:37] = cls;
        u[36:33] = typ;
        u[32]    = dv;
        u[31:27] = d;
        u[26:22] = s2;
        u[21:17] = s1;
        u[16:12] = s0;
        u[11:0]  = imm;
        return u;
    endfunction

    // Random instruction generator: builds the word from a category and, alongside,
    // the micro-ops that category must produce.
    task automatic gen(output logic [31:0] ins, output int n,
                       output logic [63:0] ua, output logic [63:0] ub);
        logic [3:0]  cond, op;
        logic [4:0]  rd, rn, rm, rs, dd, amt;
        logic [1:0]  sht;
        logic [11:0] imm, lo;
        logic        s, tst, l, b, u, a;
        int          kind;
        kind = $urandom_range(0, 6);
        cond = 4'($urandom_range(0, 14));
        op   = 4'($urandom_range(0, 15));
        rd   = 5'($urandom_range(0, 15));
        rn   = 5'($urandom_range(0, 15));
        rm   = 5'($urandom_range(0, 15));
        rs   = 5'($urandom_range(0, 15));
        imm  = 12'($urandom_range(0, 4095));
        sht  = 2'($urandom_range(0, 3));
        amt  = 5'($urandom_range(0, 31));
        l    = 1'($urandom_range(0, 1));
        b    = 1'($urandom_range(0, 1));
        u    = 1'($urandom_range(0, 1));
        a    = 1'($urandom_range(0, 1));
        tst  = (op >= 4'd8) && (op <= 4'd11);
        s    = tst ? 1'b1 : 1'($urandom_range(0, 1));
        dd   = tst ? 5'd0 : rd;
        ua = 64'd0;
        ub = 64'd0;
        n  = 0;
        case (kind)
            0: begin
                ins = {cond, 3'b001, op, s, rn[3:0], rd[3:0], imm};
                ua  = mk(cond, 3'd1, 4'd1, imm, rn, 5'd0, 5'd0, dd, !tst);
                n   = 1;
            end
            1: begin
                ins = {cond, 3'b000, op, s, rn[3:0], rd[3:0], 8'h00, rm[3:0]};
                ua  = mk(cond, 3'd1, 4'd0, 12'd0, rn, rm, 5'd0, dd, !tst);
                n   = 1;
            end
            2: begin
                if (amt == 5'd0 && sht == 2'd0) amt = 5'd1;
                lo  = {amt, sht, 1'b0, rm[3:0]};
                ins = {cond, 3'b000, op, s, rn[3:0], rd[3:0], lo};
                ua  = mk(4'hE, 3'd1, 4'd4 + {2'b00, sht}, lo, 5'd0, rm, 5'd0, 5'd16, 1'b1);
                ub  = mk(cond, 3'd1, 4'd0, 12'd0, rn, 5'd16, 5'd0, dd, !tst);
                n   = 2;
            end
            3: begin
                lo  = {rs[3:0], 1'b0, sht, 1'b1, rm[3:0]};
                ins = {cond, 3'b000, op, s, rn[3:0], rd[3:0], lo};
                ua  = mk(4'hE, 3'd1, 4'd4 + {2'b00, sht}, lo, 5'd0, rm, rs, 5'd16, 1'b1);
                ub  = mk(cond, 3'd1, 4'd0, 12'd0, rn, 5'd16, 5'd0, dd, !tst);
                n   = 2;
            end
            4: begin
                ins = {cond, 6'b000000, a, s, rd[3:0], rn[3:0], rs[3:0], 4'b1001, rm[3:0]};
                ua  = mk(cond, 3'd2, 4'd0, 12'd0, rm, rs, rn, rd, 1'b1);
                n   = 1;
            end
            5: begin
                ins = {cond, 2'b01, 1'b0, 1'b1, u, b, 1'b0, l, rn[3:0], rd[3:0], imm};
                ua  = l ? mk(cond, 3'd3, 4'd1, imm, rn, 5'd0, 5'd0, rd, 1'b1)
                        : mk(cond, 3'd4, 4'd1, imm, rn, rd, 5'd0, 5'd0, 1'b0);
                n   = 1;
            end
            default: begin
                ins = {cond, 8'h32, 4'h0, 4'hF, 4'h0, 8'($urandom_range(0, 4))};
            end
        endcase
    endtask

    typedef struct {
        logic [31:0] instr;
        int          n;
        logic [63:0] a;
        logic [63:0] b;
    } vec_t;

    localparam int NV = 14;
    vec_t        vt[NV];
    logic [63:0] mq[$];
    logic [63:0] m_out, ua, ub, add_uop;
    logic [31:0] ins;
    logic [31:0] m_instr, m_uop, m_stall;
    logic        m_ready;
    int          n;

    initial begin
        add_uop = mk(4'hE, 3'd1, 4'd1, 12'h005, 5'd2, 5'd0, 5'd0, 5'd1, 1'b1);
        vt[0]  = '{32'hE2821005, 1, add_uop, 64'd0};
        vt[1]  = '{32'hE0810182, 2, mk(4'hE, 3'd1, 4'd4, 12'h182, 5'd0, 5'd2, 5'd0, 5'd16, 1'b1),
                                    mk(4'hE, 3'd1, 4'd0, 12'h000, 5'd1, 5'd16, 5'd0, 5'd0, 1'b1)};
        vt[2]  = '{32'hE3530000, 1, mk(4'hE, 3'd1, 4'd1, 12'h000, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0), 64'd0};
        vt[3]  = '{32'hE320F000, 0, 64'd0, 64'd0};
        vt[4]  = '{32'hE0454006, 1, mk(4'hE, 3'd1, 4'd0, 12'h000, 5'd5, 5'd6, 5'd0, 5'd4, 1'b1), 64'd0};
        vt[5]  = '{32'h11A07958, 2, mk(4'hE, 3'd1, 4'd6, 12'h958, 5'd0, 5'd8, 5'd9, 5'd16, 1'b1),
                                    mk(4'h1, 3'd1, 4'd0, 12'h000, 5'd0, 5'd16, 5'd0, 5'd7, 1'b1)};
        vt[6]  = '{32'hE0214392, 1, mk(4'hE, 3'd2, 4'd0, 12'h000, 5'd2, 5'd3, 5'd4, 5'd1, 1'b1), 64'd0};
        vt[7]  = '{32'hE5965010, 1, mk(4'hE, 3'd3, 4'd1, 12'h010, 5'd6, 5'd0, 5'd0, 5'd5, 1'b1), 64'd0};
        vt[8]  = '{32'hE5832004, 1, mk(4'hE, 3'd4, 4'd1, 12'h004, 5'd3, 5'd2, 5'd0, 5'd0, 1'b0), 64'd0};
        vt[9]  = '{32'hE1110002, 1, mk(4'hE, 3'd1, 4'd0, 12'h000, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0), 64'd0};
        vt[10] = '{32'hF57FF01F, 0, 64'd0, 64'd0};
        vt[11] = '{32'hE7F000F0, 0, 64'd0, 64'd0};
        vt[12] = '{32'hE1A00000, 1, mk(4'hE, 3'd1, 4'd0, 12'h000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1), 64'd0};
        vt[13] = '{32'hE1821023, 2, mk(4'hE, 3'd1, 4'd5, 12'h023, 5'd0, 5'd3, 5'd0, 5'd16, 1'b1),
                                    mk(4'hE, 3'd1, 4'd0, 12'h000, 5'd2, 5'd16, 5'd0, 5'd1, 1'b1)};

        // Reset held with an instruction offered.
        instr_valid_i = 1'b1;
        instr_i       = 32'hE2821005;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 64'(instr_ready_o), 64'd0);
        check("rst_valid", 64'(uop_valid_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_uop", uop_o, 64'd0);
        instr_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        check("add_count", 64'(count_o), 64'd1);
        check("add_valid", 64'(uop_valid_o), 64'd1);
        check("add_uop", uop_o, add_uop);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;

        // Stall: issue blocked, single-uop stream until the two-slot reserve closes.
        instr_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("stall%0d_count", k), 64'(count_o), 64'((k < 3) ? k : 3));
            check($sformatf("stall%0d_ready", k), 64'(instr_ready_o), 64'(k < 3));
            tick();
        end
        check("stall_count_final", 64'(count_o), 64'd3);

        // Flush with an instruction offered: rejected, queue empty next cycle.
        flush_i = 1'b1;
        #1;
        check("flush_ready", 64'(instr_ready_o), 64'd0);
        tick();
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_valid", 64'(uop_valid_o), 64'd0);
        check("flush_uop_hold", uop_o, add_uop);
`ifdef UOP_DECODE_STATS_EN
        check("stat_instr_dir", 64'(stat_instr_o), 64'd4);
        check("stat_stall_dir", 64'(stat_stall_o), 64'd3);
        check("stat_uop_dir", 64'(stat_uop_o), 64'd0);
`endif

        // Decode table.
        for (int i = 0; i < NV; i++) begin
            instr_i       = vt[i].instr;
            instr_valid_i = 1'b1;
            tick();
            instr_valid_i = 1'b0;
            check($sformatf("vec%0d_count", i), 64'(count_o), 64'(vt[i].n));
            if (vt[i].n > 0) check($sformatf("vec%0d_uopA", i), uop_o, vt[i].a);
            if (vt[i].n == 2) begin
                uop_ready_i = 1'b1;
                tick();
                uop_ready_i = 1'b0;
                check($sformatf("vec%0d_uopB", i), uop_o, vt[i].b);
                check($sformatf("vec%0d_count_b", i), 64'(count_o), 64'd1);
            end
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
        end

        // Asynchronous reset with a pair in the queue.
        instr_i       = 32'hE0810182;
        instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_valid", 64'(uop_valid_o), 64'd0);
        check("arst_uop", uop_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Randomized run against the queue model.
        m_out   = 64'd0;
        m_instr = 32'd0;
        m_uop   = 32'd0;
        m_stall = 32'd0;
        mq.delete();
        for (int c = 0; c < 800; c++) begin
            check("rnd_count", 64'(count_o), 64'(mq.size()));
            check("rnd_valid", 64'(uop_valid_o), 64'(mq.size() != 0));
            check("rnd_uop", uop_o, m_out);
            gen(ins, n, ua, ub);
            instr_i       = ins;
            instr_valid_i = ($urandom_range(0, 3) != 0);
            uop_ready_i   = ($urandom_range(0, 3) != 0);
            flush_i       = ($urandom_range(0, 49) == 0);
            m_ready = !flush_i && ((DEPTH - mq.size()) >= 2);
            #1;
            check("rnd_ready", 64'(instr_ready_o), 64'(m_ready));
            if (instr_valid_i && !m_ready) m_stall++;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (mq.size() != 0 && uop_ready_i) begin
                    void'(mq.pop_front());
                    m_uop++;
                end
                if (instr_valid_i && m_ready) begin
                    m_instr++;
                    if (n >= 1) mq.push_back(ua);
                    if (n == 2) mq.push_back(ub);
                end
            end
            if (mq.size() != 0) m_out = mq[0];
            tick();
        end
`ifdef UOP_DECODE_STATS_EN
        check("stat_instr_rnd", 64'(stat_instr_o), 64'(m_instr));
        check("stat_uop_rnd", 64'(stat_uop_o), 64'(m_uop));
        check("stat_stall_rnd", 64'(stat_stall_o), 64'(m_stall));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
